// File: rtl/div_pkg.sv
// Shared definitions for the sequential repeated-subtraction divider.
// Optional divide-by-zero flagging is enabled with the DIV_ZERO_CHK_EN macro.
package div_pkg;

   localparam int unsigned DIV_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LD_A = 3'd1,
      ST_LD_B = 3'd2,
      ST_CALC = 3'd3,
      ST_DONE = 3'd4
   } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: remainder and divisor registers, quotient counter,
// subtractor and the compare flags consumed by the control FSM.
module div_datapath
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ld_a,
   input  logic             i_ld_b,
   input  logic             i_sub,
   input  logic             i_q_ones,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_r,
   output logic             o_ge,
   output logic             o_eqz
);

   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_diff;

   assign w_diff = r_r - r_b;
   assign o_ge   = (r_r >= r_b);
   assign o_eqz  = (r_b == '0);
   assign o_q    = r_q;
   assign o_r    = r_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_r <= '0;
         r_b <= '0;
         r_q <= '0;
      end else begin
         if (i_ld_a) begin
            r_r <= i_data;
            r_q <= '0;
         end else if (i_sub) begin
            r_r <= w_diff;
            r_q <= r_q + 1'b1;
         end else if (i_q_ones) begin
            r_q <= '1;
         end
         if (i_ld_b) begin
            r_b <= i_data;
         end
      end
   end

endmodule

// File: rtl/div_seq.sv
// Sequential repeated-subtraction divider: FSM control around div_datapath.
// Define DIV_ZERO_CHK_EN to flag a zero divisor and saturate the quotient.
module div_seq
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done,
   output logic             busy,
   output logic             div_by_zero
);

   div_state_t r_state;
   div_state_t w_next;

   logic w_ld_a;
   logic w_ld_b;
   logic w_sub;
   logic w_q_ones;
   logic w_dbz_set;
   logic w_ge;
   logic w_eqz;

   div_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_ld_a   (w_ld_a),
      .i_ld_b   (w_ld_b),
      .i_sub    (w_sub),
      .i_q_ones (w_q_ones),
      .i_data   (data_in),
      .o_q      (quotient),
      .o_r      (remainder),
      .o_ge     (w_ge),
      .o_eqz    (w_eqz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_ld_a    = 1'b0;
      w_ld_b    = 1'b0;
      w_sub     = 1'b0;
      w_q_ones  = 1'b0;
      w_dbz_set = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_LD_A;
         end
         ST_LD_A: begin
            w_ld_a = 1'b1;
            w_next = ST_LD_B;
         end
         ST_LD_B: begin
            w_ld_b = 1'b1;
            w_next = ST_CALC;
         end
         ST_CALC: begin
            // Zero guard is checked first so CALC can never loop on B==0.
            if (w_eqz) begin
               w_next = ST_DONE;
`ifdef DIV_ZERO_CHK_EN
               w_q_ones  = 1'b1;
               w_dbz_set = 1'b1;
`endif
            end else if (w_ge) begin
               w_sub = 1'b1;
            end else begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!start) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign done = (r_state == ST_DONE);
   assign busy = (r_state == ST_LD_A) || (r_state == ST_LD_B) || (r_state == ST_CALC);

`ifdef DIV_ZERO_CHK_EN
   logic r_dbz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dbz <= 1'b0;
      end else if (w_ld_a) begin
         r_dbz <= 1'b0;
      end else if (w_dbz_set) begin
         r_dbz <= 1'b1;
      end else if ((r_state == ST_DONE) && (w_next != ST_DONE)) begin
         r_dbz <= 1'b0;
      end
   end

   assign div_by_zero = r_dbz;
`else
   logic w_dbz_unused;
   assign w_dbz_unused = w_dbz_set;
   assign div_by_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: randomized and directed divisions checked
// against a quotient/remainder model; a WIDTH=8 instance covers the wide-quotient case.
module tb_div_seq;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] din;
   logic [15:0] q, r;
   logic        done, busy, dbz;

   logic        start8;
   logic [7:0]  din8;
   logic [7:0]  q8, r8;
   logic        done8, busy8, dbz8;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   t_start = 0;
   logic prev_done = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   div_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(din),
      .quotient(q), .remainder(r), .done(done), .busy(busy), .div_by_zero(dbz)
   );

   div_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .data_in(din8),
      .quotient(q8), .remainder(r8), .done(done8), .busy(busy8), .div_by_zero(dbz8)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      if (b == 16'd0) begin
`ifdef DIV_ZERO_CHK_EN
         e.q = 16'hFFFF;
         e.dbz = 1'b1;
`else
         e.q = 16'd0;
         e.dbz = 1'b0;
`endif
         e.r = a;
         e.lat = 3;
      end else begin
         e.q = a / b;
         e.r = a % b;
         e.dbz = 1'b0;
         e.lat = int'(e.q) + 3;
      end
      return e;
   endfunction

   // Monitor: compare each new result against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done && !prev_done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no result pending");
         end else begin
            e = sb.pop_front();
            chk("quotient", {16'd0, q}, {16'd0, e.q});
            chk("remainder", {16'd0, r}, {16'd0, e.r});
            chk("div_by_zero", {31'd0, dbz}, {31'd0, e.dbz});
            chk("latency", cyc - t_start, e.lat);
         end
      end
      prev_done = done;
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
      exp_t e;
      int   n;
      e = model(a, b);
      @(negedge clk);
      start = 1'b1;
      din   = 16'($urandom);
      @(negedge clk);
      t_start = cyc;
      chk("busy_in_ld_a", {31'd0, busy}, 32'd1);
      din = a;
      sb.push_back(e);
      @(negedge clk);
      din = b;
      @(negedge clk);
      din = 16'($urandom);
      n = 0;
      while (!done && n < 5000) begin
         @(negedge clk);
         din = 16'($urandom);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1", n);
         start = 1'b0;
         sb.delete();
         apply_reset();
         return;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         din = 16'($urandom);
         chk("hold_done", {31'd0, done}, 32'd1);
         chk("hold_quotient", {16'd0, q}, {16'd0, e.q});
         chk("hold_remainder", {16'd0, r}, {16'd0, e.r});
      end
      start = 1'b0;
      @(negedge clk);
      chk("release_done", {31'd0, done}, 32'd0);
      chk("release_busy", {31'd0, busy}, 32'd0);
      chk("release_dbz", {31'd0, dbz}, 32'd0);
   endtask

   initial begin
      logic [15:0] a, b;
      int n;
      rst_n  = 1'b0;
      start  = 1'b0;
      din    = '0;
      start8 = 1'b0;
      din8   = '0;
      repeat (2) @(negedge clk);
      chk("rst_quotient", {16'd0, q}, 32'd0);
      chk("rst_remainder", {16'd0, r}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_dbz", {31'd0, dbz}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(16'd17, 16'd5, 3);
      run_op(16'd5, 16'd17, 1);
      run_op(16'd16, 16'd4, 2);
      run_op(16'd9, 16'd0, 3);
      run_op(16'd0, 16'd7, 1);
      run_op(16'd0, 16'd0, 1);

      // Abort 200/3 two cycles into CALC.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      din = 16'd200;
      @(negedge clk);
      din = 16'd3;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_quotient", {16'd0, q}, 32'd0);
      chk("abort_remainder", {16'd0, r}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_dbz", {31'd0, dbz}, 32'd0);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_idle_busy", {31'd0, busy}, 32'd0);
      run_op(16'd10, 16'd3, 1);

      for (int i = 0; i < 20; i++) begin
         a = 16'($urandom_range(0, 1000));
         b = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 64));
         run_op(a, b, int'($urandom_range(1, 3)));
      end
      run_op(16'hFFFF, 16'hFFFF, 1);
      run_op(16'd300, 16'd299, 1);

      // WIDTH=8: 255/1 must reach Q=255 without wrapping.
      @(negedge clk);
      start8 = 1'b1;
      @(negedge clk);
      t_start = cyc;
      din8 = 8'd255;
      @(negedge clk);
      din8 = 8'd1;
      n = 0;
      while (!done8 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("w8_done", {31'd0, done8}, 32'd1);
      chk("w8_latency", cyc - t_start, 32'd258);
      chk("w8_quotient", {24'd0, q8}, 32'd255);
      chk("w8_remainder", {24'd0, r8}, 32'd0);
      chk("w8_dbz", {31'd0, dbz8}, 32'd0);
      start8 = 1'b0;
      @(negedge clk);
      chk("w8_release", {31'd0, done8}, 32'd0);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
